// File: rtl/booth_mul32_seq_if.sv
// Request/response bundle between a client and the sequential Booth multiplier.
// The client owns op_start, op_clear and the operands; the multiplier owns result, op_done and busy.
interface booth_mul32_seq_if #(
    parameter int WIDTH = 32
);
    logic               op_start;
    logic               op_clear;
    logic [WIDTH-1:0]   multiplier;
    logic [WIDTH-1:0]   multiplicand;
    logic [2*WIDTH-1:0] result;
    logic               op_done;
    logic               busy;

    modport master (
        output op_start,
        output op_clear,
        output multiplier,
        output multiplicand,
        input  result,
        input  op_done,
        input  busy
    );

    modport slave (
        input  op_start,
        input  op_clear,
        input  multiplier,
        input  multiplicand,
        output result,
        output op_done,
        output busy
    );
endinterface

// File: rtl/booth_mul32_seq.sv
// Sequential radix-2 Booth multiplier, signed 32x32 -> 64, one step per clock.
// Each EXEC step runs U +/- M through a carry-lookahead adder and arithmetic-shifts {U, Q, q_m1}.
module booth_mul32_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    booth_mul32_seq_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_u;
    logic [WIDTH-1:0]   r_q;
    logic               r_q_m1;
    logic [2*WIDTH-1:0] r_result;
    logic               r_busy;
    logic               r_done;

    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    // Adder-side signals
    logic               w_add_en;
    logic               w_sub;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_g;
    logic [WIDTH-1:0]   w_p;
    logic [WIDTH:0]     w_c;
    logic [WIDTH-1:0]   w_sum;
    logic               w_co;
    logic               w_co_prev;

    // Shift-stage signals
    logic [WIDTH-1:0]   w_u_sel;
    logic               w_sign;
    logic [WIDTH-1:0]   w_u_nxt;
    logic [WIDTH-1:0]   w_q_nxt;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_load = !bus.op_clear && bus.op_start &&
                    ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_step = !bus.op_clear && (r_state == ST_EXEC);

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state is updated with non-blocking (<=) assignments so every
    // flop samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // NOTE: the default assignment at the top of each always_comb guarantees every path
    // assigns the variable, so no latch is inferred when a branch leaves it untouched.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.op_clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.op_start) w_state_nxt = ST_EXEC;
                ST_EXEC: if (w_last)       w_state_nxt = ST_DONE;
                ST_DONE: if (bus.op_start) w_state_nxt = ST_EXEC;
                default:                   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // busy/op_done are decoded from the next state and registered alongside it.
    always_comb begin
        w_busy_nxt = (w_state_nxt == ST_EXEC);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // ---------------------------------------------------- lookahead adder
    always_comb begin
        w_add_en = r_q[0] ^ r_q_m1;
        w_sub    = r_q[0] & ~r_q_m1;
        w_b      = w_sub ? ~r_m : r_m;
        w_g      = r_u & w_b;
        w_p      = r_u ^ w_b;
        w_c      = '0;
        w_c[0]   = w_sub;
        for (int k = 0; k < WIDTH / 4; k++) begin
            w_c[4*k+1] = w_g[4*k]
                       | (w_p[4*k] & w_c[4*k]);
            w_c[4*k+2] = w_g[4*k+1]
                       | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+3] = w_g[4*k+2]
                       | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+4] = w_g[4*k+3]
                       | (w_p[4*k+3] & w_g[4*k+2])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
        end
        w_sum     = w_p ^ w_c[WIDTH-1:0];
        w_co      = w_c[WIDTH];
        w_co_prev = w_c[WIDTH-1];
    end

    // ------------------------------------------------------- shift stage
    // The sign shifted into U must be the true sign of U +/- M; s[31] alone is wrong on overflow.
    always_comb begin
        w_u_sel = w_add_en ? w_sum : r_u;
        w_sign  = w_add_en ? (w_sum[WIDTH-1] ^ (w_co_prev ^ w_co)) : r_u[WIDTH-1];
        w_u_nxt = {w_sign, w_u_sel[WIDTH-1:1]};
        w_q_nxt = {w_u_sel[0], r_q[WIDTH-1:1]};
    end

    // ---------------------------------------------------------- datapath
    // NOTE: every datapath register is cleared on reset so no stale product or operand
    // from an aborted multiply can ever be observed after reset_n is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m      <= '0;
            r_u      <= '0;
            r_q      <= '0;
            r_q_m1   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (bus.op_clear) begin
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_load) begin
            r_m      <= bus.multiplicand;
            r_u      <= '0;
            r_q      <= bus.multiplier;
            r_q_m1   <= 1'b0;
            r_cnt    <= '0;
        end else if (w_step) begin
            r_u      <= w_u_nxt;
            r_q      <= w_q_nxt;
            r_q_m1   <= r_q[0];
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result <= {w_u_nxt, w_q_nxt};
            end
        end
    end

    assign bus.result  = r_result;
    assign bus.op_done = r_done;
    assign bus.busy    = r_busy;

endmodule

// File: tb/tb_booth_mul32_seq.sv
// Directed bench for booth_mul32_seq: table of signed products plus handshake,
// clear and reset-abort sequences. Inputs change and outputs are sampled on the falling edge.
module tb_booth_mul32_seq;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    booth_mul32_seq_if #(.WIDTH(32)) bus ();

    booth_mul32_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] mplier;
        logic [31:0] mcand;
        logic [63:0] prod;
        string       name;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Waits (bounded) for op_done; lat counts rising edges since the accepting edge.
    task automatic wait_done(input logic [63:0] prior, input string name, inout int lat);
        while (!bus.op_done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 16) check($sformatf("%s/hold_mid", name), bus.result, prior);
        end
    endtask

    task automatic run_mul(input string name, input logic [31:0] mplier,
                           input logic [31:0] mcand, input logic [63:0] exp);
        logic [63:0] prior;
        int lat;
        prior            = bus.result;
        bus.multiplier   = mplier;
        bus.multiplicand = mcand;
        bus.op_start     = 1'b1;
        @(negedge clk);
        bus.op_start = 1'b0;
        lat = 0;
        check($sformatf("%s/busy", name), 64'(bus.busy), 64'd1);
        check($sformatf("%s/done_low", name), 64'(bus.op_done), 64'd0);
        wait_done(prior, name, lat);
        check($sformatf("%s/latency", name), 64'(lat), 64'd32);
        check($sformatf("%s/result", name), bus.result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;

        vecs[0] = '{32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, "7x-3"};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_x_min"};
        vecs[2] = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, "max_x_min"};
        vecs[3] = '{32'd0,         32'h1234_5678, 64'h0000_0000_0000_0000, "zero"};
        vecs[4] = '{32'd1,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "one_x_m1"};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "m1_x_m1"};
        vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "min_x_m1"};
        vecs[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, "max_x_max"};
        vecs[8] = '{32'h0000_FFFF, 32'h0001_0000, 64'h0000_0000_FFFF_0000, "ffff_x_10000"};

        bus.op_start     = 1'b0;
        bus.op_clear     = 1'b0;
        bus.multiplier   = '0;
        bus.multiplicand = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset/result", bus.result, 64'd0);
        check("reset/done", 64'(bus.op_done), 64'd0);
        check("reset/busy", 64'(bus.busy), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle/busy", 64'(bus.busy), 64'd0);
        check("idle/done", 64'(bus.op_done), 64'd0);

        // Table of products; each after the first restarts straight from DONE
        for (int i = 0; i < 9; i++) begin
            run_mul(vecs[i].name, vecs[i].mplier, vecs[i].mcand, vecs[i].prod);
        end

        // op_start held through EXEC with changing operands: only the first pair counts
        bus.multiplier   = 32'h0000_1234;
        bus.multiplicand = 32'h0000_0100;
        bus.op_start     = 1'b1;
        @(negedge clk);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            bus.multiplier   = $urandom;
            bus.multiplicand = $urandom;
            @(negedge clk);
            lat++;
        end
        bus.op_start = 1'b0;
        check("held/busy", 64'(bus.busy), 64'd1);
        wait_done(bus.result, "held", lat);
        check("held/latency", 64'(lat), 64'd32);
        check("held/result", bus.result, 64'h0000_0000_0012_3400);

        // Restart from DONE
        run_mul("done_restart", 32'd5, 32'd6, 64'd30);

        // Asynchronous reset at EXEC cycle 10
        bus.multiplier   = 32'd7;
        bus.multiplicand = 32'hFFFF_FFFD;
        bus.op_start     = 1'b1;
        @(negedge clk);
        bus.op_start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid/result", bus.result, 64'd0);
        check("rst_mid/done", 64'(bus.op_done), 64'd0);
        check("rst_mid/busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_mid/idle_busy", 64'(bus.busy), 64'd0);
        check("rst_mid/idle_done", 64'(bus.op_done), 64'd0);
        run_mul("after_reset", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);

        // op_clear at EXEC cycle 15 aborts without an op_done pulse
        bus.multiplier   = 32'h7FFF_FFFF;
        bus.multiplicand = 32'h7FFF_FFFF;
        bus.op_start     = 1'b1;
        @(negedge clk);
        bus.op_start = 1'b0;
        repeat (14) @(negedge clk);
        bus.op_clear = 1'b1;
        @(negedge clk);
        bus.op_clear = 1'b0;
        check("clr_mid/busy", 64'(bus.busy), 64'd0);
        check("clr_mid/done", 64'(bus.op_done), 64'd0);
        check("clr_mid/result", bus.result, 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.op_done || bus.busy) seen++;
        end
        check("clr_mid/no_activity", 64'(seen), 64'd0);

        // op_clear beats op_start in DONE
        run_mul("pre_clr", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        bus.op_start = 1'b1;
        bus.op_clear = 1'b1;
        @(negedge clk);
        bus.op_start = 1'b0;
        bus.op_clear = 1'b0;
        check("clr_start_done/busy", 64'(bus.busy), 64'd0);
        check("clr_start_done/done", 64'(bus.op_done), 64'd0);
        check("clr_start_done/result", bus.result, 64'd0);

        // op_clear beats op_start in IDLE
        bus.op_start = 1'b1;
        bus.op_clear = 1'b1;
        @(negedge clk);
        bus.op_start = 1'b0;
        bus.op_clear = 1'b0;
        @(negedge clk);
        check("clr_start_idle/busy", 64'(bus.busy), 64'd0);
        check("clr_start_idle/done", 64'(bus.op_done), 64'd0);

        run_mul("final", 32'd5, 32'd6, 64'd30);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
